// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//
// Turns the SPI-written configuration registers into the 16 chip outputs.
// Each output bit is forced low, held static high, or driven by one shared
// PWM waveform. The waveform comes from a free-running 8-bit counter advanced
// by a prescaler, so one PWM period is 256*CLK_DIV clocks.
//
// Optional build macro:
//   PWM_SHADOW_EN  - when defined, the duty cycle is sampled into a shadow
//                    register only at the period wrap, so a mid-period duty
//                    change never truncates or stretches a pulse. When
//                    undefined, the duty input is used directly and a change
//                    takes effect on the very next compare.
//
// Parameters:
//   CLK_DIV          system clocks per PWM counter step (legal 1..65535)
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, bits 7:0
//   en_reg_out_15_8  output enable, bits 15:8
//   en_reg_pwm_7_0   PWM-mode select, bits 7:0
//   en_reg_pwm_15_8  PWM-mode select, bits 15:8
//   pwm_duty_cycle   shared duty; 0x00 = always low, 0xFF = always high
//   out              registered chip outputs
//   period_start     registered one-clock pulse in the first cycle of a period
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // A divide-by-one still needs a one-bit prescaler that simply stays at 0.
    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] prescaler_reg;
    logic [PRESC_W-1:0] prescaler_next;
    logic [7:0]         pwm_cnt_reg;
    logic [7:0]         pwm_cnt_next;
    logic               tick;
    logic               wrap;

    logic [7:0]         duty_active;
    logic               pwm_sig;

    logic [15:0]        en_out;
    logic [15:0]        en_pwm;
    logic [15:0]        out_next;
    logic [15:0]        out_reg;
    logic               period_start_reg;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // -------------------------------------------------------------------------
    // Prescaler and PWM counter; both free-run regardless of the enables.
    // -------------------------------------------------------------------------
    always_comb begin
        tick           = (prescaler_reg == PRESC_LAST);
        prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
        // 8-bit arithmetic wraps 255 -> 0 naturally.
        pwm_cnt_next   = tick ? pwm_cnt_reg + 8'd1 : pwm_cnt_reg;
        wrap           = tick && (pwm_cnt_reg == 8'hFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_reg <= '0;
            pwm_cnt_reg   <= 8'd0;
        end else begin
            prescaler_reg <= prescaler_next;
            pwm_cnt_reg   <= pwm_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Duty source
    // -------------------------------------------------------------------------
`ifdef PWM_SHADOW_EN
    logic [7:0] duty_shadow_reg;

    // Loading on the wrap cycle means the new value is in place exactly when
    // the counter reads 0 again; a change coinciding with the wrap is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_reg <= 8'd0;
        end else if (wrap) begin
            duty_shadow_reg <= pwm_duty_cycle;
        end
    end

    assign duty_active = duty_shadow_reg;
`else
    assign duty_active = pwm_duty_cycle;
`endif

    // 0xFF is special-cased to a solid high rather than 255/256.
    assign pwm_sig = (duty_active == 8'hFF) || (pwm_cnt_reg < duty_active);

    // -------------------------------------------------------------------------
    // Per-bit output mux: disabled -> 0, static -> 1, PWM -> shared waveform.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_out_mux
            assign out_next[gi] = en_out[gi] & (~en_pwm[gi] | pwm_sig);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg          <= 16'h0000;
            period_start_reg <= 1'b0;
        end else begin
            out_reg          <= out_next;
            // Registering wrap lands the pulse in the cycle where pwm_cnt is 0.
            period_start_reg <= wrap;
        end
    end

    assign out          = out_reg;
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//
// Scoreboard bench for pwm_peripheral. The stimulus process drives the
// configuration inputs on the falling edge and pushes the expected outputs
// for the following rising edge into a queue; an independent monitor pops
// and compares one entry after every rising edge. The reference model works
// from elapsed cycles since reset release: counter value = (t / CLK_DIV) mod
// 256, period boundary = t mod (256*CLK_DIV).
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    typedef struct {
        logic [15:0] out;
        logic        ps;
        longint      t;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Model state
    longint      t = 0;
    logic [7:0]  shadow_duty = 8'd0;
    logic [15:0] cfg_en_out = 16'hFFFF;
    logic [15:0] cfg_en_pwm = 16'hFFFF;
    logic [7:0]  cfg_duty   = 8'hFF;

    function automatic exp_t model(longint tc, logic [7:0] duty,
                                   logic [15:0] eo, logic [15:0] ep);
        exp_t e;
        int   cnt;
        bit   lvl;
        cnt = int'((tc / CLK_DIV) % 256);
        if (duty == 8'hFF) lvl = 1'b1;
        else               lvl = (cnt < int'(duty));
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])      e.out[i] = 1'b0;
            else if (!ep[i]) e.out[i] = 1'b1;
            else             e.out[i] = lvl;
        end
        e.ps = ((tc % PERIOD) == PERIOD - 1);
        e.t  = tc;
        return e;
    endfunction

    // Counter value of the next cycle to be driven.
    function automatic int cur_cnt();
        return int'((t / CLK_DIV) % 256);
    endfunction

    // One clock cycle of stimulus plus its expectation.
    task automatic cycle(input bit release_rst);
        exp_t       e;
        logic [7:0] duty_eff;
        @(negedge clk);
        if (release_rst) begin
            rst_n       = 1'b1;
            t           = 0;
            shadow_duty = 8'd0;
        end
        {en_reg_out_15_8, en_reg_out_7_0} = cfg_en_out;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = cfg_en_pwm;
        pwm_duty_cycle                    = cfg_duty;
        if (!rst_n) begin
            e.out = 16'h0000;
            e.ps  = 1'b0;
            e.t   = -1;
            exp_q.push_back(e);
        end else begin
`ifdef PWM_SHADOW_EN
            duty_eff = shadow_duty;
`else
            duty_eff = cfg_duty;
`endif
            exp_q.push_back(model(t, duty_eff, cfg_en_out, cfg_en_pwm));
            // Duty present during the last cycle of a period rules the next one.
            if ((t % PERIOD) == PERIOD - 1) shadow_duty = cfg_duty;
            t++;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0);
    endtask

    task automatic run_until_cnt(input int target);
        for (int k = 0; k < PERIOD && cur_cnt() != target; k++) cycle(1'b0);
    endtask

    task automatic reset_and_release();
        repeat (3) cycle(1'b0);
        cycle(1'b1);
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out=%h period_start=%b, required out=0000 period_start=0",
                     out, period_start);
        end
    endtask

    task automatic report(input int seg, input string name, input int c0, input int e0);
        $display("segment %0d %s: checks=%0d errors=%0d t=%0d",
                 seg, name, checks - c0, errors - e0, t);
    endtask

    // Monitor: one comparison per rising edge when an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out !== e.out || period_start !== e.ps) begin
                    errors++;
                    $display("FAIL cycle_check t=%0d: out=%h period_start=%b, required out=%h period_start=%b",
                             e.t, out, period_start, e.out, e.ps);
                end
            end
        end
    end

    initial begin
        int c0, e0, len;
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'hFF;
        en_reg_pwm_15_8 = 8'hFF;
        pwm_duty_cycle  = 8'hFF;

        // 1: reset with all inputs high, release, first period boundary
        c0 = checks; e0 = errors;
        reset_and_release();
        run(PERIOD + 20);
        report(1, "reset_release_all_ff", c0, e0);

        // 2: static enables only, ten periods
        c0 = checks; e0 = errors;
        cfg_en_out = 16'h00FF; cfg_en_pwm = 16'h0000; cfg_duty = 8'h80;
        run(10 * PERIOD);
        report(2, "static_00ff", c0, e0);

        // 3: 50% duty on all outputs
        c0 = checks; e0 = errors;
        cfg_en_out = 16'hFFFF; cfg_en_pwm = 16'hFFFF; cfg_duty = 8'h80;
        run(2 * PERIOD);
        report(3, "duty_80", c0, e0);

        // 4: duty extremes
        c0 = checks; e0 = errors;
        cfg_duty = 8'h00;
        run(2 * PERIOD);
        cfg_duty = 8'hFF;
        run(2 * PERIOD);
        report(4, "duty_00_then_ff", c0, e0);

        // 5: duty change mid-period at counter 0x60
        c0 = checks; e0 = errors;
        cfg_duty = 8'h40;
        run(PERIOD);
        run_until_cnt(8'h60);
        cfg_duty = 8'hC0;
        run(2 * PERIOD);
        report(5, "duty_40_to_c0_mid", c0, e0);

        // 6: randomized configurations with sporadic mid-segment changes
        for (int s = 0; s < 24; s++) begin
            c0 = checks; e0 = errors;
            cfg_en_out = 16'($urandom);
            cfg_en_pwm = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       cfg_duty = 8'h00;
                1:       cfg_duty = 8'hFF;
                2:       cfg_duty = 8'h01;
                3:       cfg_duty = 8'hFE;
                default: cfg_duty = 8'($urandom);
            endcase
            len = $urandom_range(20, 600);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 49) == 0) cfg_duty   = 8'($urandom);
                if ($urandom_range(0, 79) == 0) cfg_en_pwm = 16'($urandom);
                if ($urandom_range(0, 79) == 0) cfg_en_out = 16'($urandom);
                cycle(1'b0);
            end
            report(6, "random", c0, e0);
        end

        // 7: asynchronous reset mid-period with outputs high, then restart
        c0 = checks; e0 = errors;
        cfg_en_out = 16'hFFFF; cfg_en_pwm = 16'h0000; cfg_duty = 8'($urandom);
        run(PERIOD);
        run_until_cnt(8'h90);
        async_reset();
        cfg_en_out = 16'hFFFF; cfg_en_pwm = 16'hFFFF; cfg_duty = 8'hFF;
        reset_and_release();
        run(PERIOD + 20);
        report(7, "async_reset_restart", c0, e0);

        // Let the monitor consume the last expectations.
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
